logic_unit_seq: RTL and testbench



---
 rtl/logic_unit_seq.sv | 195 +++++++++++++++++++
 tb/tb_logic_unit_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_seq
// Function : Serial AND/OR/XOR/NOR unit. Computes one SLICE-bit slice per
//            cycle, LSB slice first, with a start / one-cycle ready handshake.
// Options  : LOGIC_UNIT_ZERO_FLAG_EN builds the result-is-zero flag (isZero).
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [1:0]       ctrl_op,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             busy,
  output logic             isZero
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic             start_ok;
  logic             run_en;
  logic             last_slice;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_res;
  logic [SLICE-1:0] a_slices [0:N-1];
  logic [SLICE-1:0] b_slices [0:N-1];
  logic [WIDTH-1:0] result_nx;

  assign start_ok   = ctrl_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign run_en     = (state_q == S_RUN);
  assign last_slice = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / registered-output decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ctrl_start) state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  state_d = ctrl_start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave flops directly.
  always_comb begin
    busy_d = (state_d == S_RUN);
    rdy_d  = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Slice datapath
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N; g++) begin : g_slice
    assign a_slices[g] = a_q[g*SLICE +: SLICE];
    assign b_slices[g] = b_q[g*SLICE +: SLICE];
    assign result_nx[g*SLICE +: SLICE] =
        (run_en && (cnt_q == CNT_W'(g))) ? slice_res : result_q[g*SLICE +: SLICE];
  end

  assign slice_a = a_slices[cnt_q];
  assign slice_b = b_slices[cnt_q];

  always_comb begin
    slice_res = '0;
    case (op_q)
      OP_AND:  slice_res = slice_a & slice_b;
      OP_OR:   slice_res = slice_a | slice_b;
      OP_XOR:  slice_res = slice_a ^ slice_b;
      OP_NOR:  slice_res = ~(slice_a | slice_b);
      default: slice_res = '0;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (start_ok) begin
      a_d      = data_operandA;
      b_d      = data_operandB;
      op_d     = ctrl_op;
      cnt_d    = '0;
      result_d = '0;
    end else if (run_en) begin
      result_d = result_nx;
      if (!last_slice) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

  // ---------------------------------------------------------------------------
  // Optional zero flag
  // ---------------------------------------------------------------------------
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic zero_acc_q, zero_acc_d;
  logic is_zero_q, is_zero_d;

  // The final slice is folded in combinationally so the flag lands with RDY.
  always_comb begin
    zero_acc_d = zero_acc_q;
    is_zero_d  = is_zero_q;
    if (start_ok) begin
      zero_acc_d = 1'b0;
      is_zero_d  = 1'b0;
    end else if (run_en) begin
      zero_acc_d = zero_acc_q | (|slice_res);
      if (last_slice) begin
        is_zero_d = ~(zero_acc_q | (|slice_res));
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      zero_acc_q <= 1'b0;
      is_zero_q  <= 1'b0;
    end else begin
      zero_acc_q <= zero_acc_d;
      is_zero_q  <= is_zero_d;
    end
  end

  assign isZero = is_zero_q;
`else
  assign isZero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_seq
// Function : Self-checking bench for logic_unit_seq (32/8, 16/16, 12/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_seq;

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        start0, start1, start2;

  logic [31:0] res0;
  logic [15:0] res1;
  logic [11:0] res2;
  logic        rdy0, rdy1, rdy2;
  logic        busy0, busy1, busy2;
  logic        zero0, zero1, zero2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc, rdy_cyc, rdy_prev;
  logic [31:0] last_exp;

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic_unit_seq #(.WIDTH(32), .SLICE(8)) u_dut (
    .clock(clock), .reset(reset), .ctrl_start(start0), .ctrl_op(op),
    .data_operandA(a), .data_operandB(b), .data_result(res0),
    .data_resultRDY(rdy0), .busy(busy0), .isZero(zero0)
  );

  logic_unit_seq #(.WIDTH(16), .SLICE(16)) u_dut_w16 (
    .clock(clock), .reset(reset), .ctrl_start(start1), .ctrl_op(op),
    .data_operandA(a[15:0]), .data_operandB(b[15:0]), .data_result(res1),
    .data_resultRDY(rdy1), .busy(busy1), .isZero(zero1)
  );

  logic_unit_seq #(.WIDTH(12), .SLICE(4)) u_dut_w12 (
    .clock(clock), .reset(reset), .ctrl_start(start2), .ctrl_op(op),
    .data_operandA(a[11:0]), .data_operandB(b[11:0]), .data_result(res2),
    .data_resultRDY(rdy2), .busy(busy2), .isZero(zero2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int cfg_width(input int sel);
    case (sel)
      0:       return 32;
      1:       return 16;
      default: return 12;
    endcase
  endfunction

  function automatic int cfg_slice(input int sel);
    case (sel)
      0:       return 8;
      1:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] low_mask(input int bits);
    logic [63:0] m;
    m = (64'd1 << bits) - 64'd1;
    return m[31:0];
  endfunction

  // Reference: whole-word bitwise operation, truncated to the instance width.
  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input int w);
    logic [31:0] r;
    case (o)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = ~(x | y);
    endcase
    return r & low_mask(w);
  endfunction

  function automatic logic [31:0] get_res(input int sel);
    case (sel)
      0:       return res0;
      1:       return {16'h0, res1};
      default: return {20'h0, res2};
    endcase
  endfunction

  function automatic logic get_rdy(input int sel);
    case (sel)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_zero(input int sel);
    case (sel)
      0:       return zero0;
      1:       return zero1;
      default: return zero2;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Issues one operation from the current cycle and follows it to its RDY
  // cycle; poke_at >= 0 raises a spurious start with fresh operands in that RUN cycle.
  task automatic run_op(input int sel, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int poke_at);
    int w, s, n;
    logic [31:0] exp;
    w   = cfg_width(sel);
    s   = cfg_slice(sel);
    n   = w / s;
    exp = ref_op(o, x, y, w);
    op  = o;
    a   = x;
    b   = y;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    start_cyc = cyc;
    check_eq("start_busy", {31'h0, get_busy(sel)}, 32'h1);
    check_eq("start_clear", get_res(sel), 32'h0);
    for (int i = 0; i < n; i++) begin
      if (i == poke_at) begin
        set_start(sel, 1'b1);
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
      end
      tick();
      set_start(sel, 1'b0);
      check_eq($sformatf("slice%0d_s%0d", i, sel), get_res(sel), exp & low_mask((i + 1) * s));
      check_eq("run_busy", {31'h0, get_busy(sel)}, {31'h0, (i < n - 1)});
      check_eq("run_rdy", {31'h0, get_rdy(sel)}, {31'h0, (i == n - 1)});
    end
    check_eq("zero_flag", {31'h0, get_zero(sel)}, {31'h0, ZERO_EN && (exp == 32'h0)});
    rdy_prev = rdy_cyc;
    rdy_cyc  = cyc;
    last_exp = exp;
  endtask

  task automatic idle(input int sel, input int cycles, input logic [31:0] exp_res);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_eq("idle_busy", {31'h0, get_busy(sel)}, 32'h0);
      check_eq("idle_rdy", {31'h0, get_rdy(sel)}, 32'h0);
      check_eq("idle_hold", get_res(sel), exp_res);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start0  = 1'b0;
    start1  = 1'b0;
    start2  = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    rdy_cyc = 0;
    rdy_prev = 0;
    last_exp = '0;

    repeat (2) tick();
    check_eq("rst_res", res0, 32'h0);
    check_eq("rst_rdy", {31'h0, rdy0}, 32'h0);
    check_eq("rst_busy", {31'h0, busy0}, 32'h0);
    check_eq("rst_zero", {31'h0, zero0}, 32'h0);
    reset = 1'b0;
    idle(0, 10, 32'h0);

    run_op(0, 2'b01, 32'hF0F00000, 32'h00000F0F, -1);
    check_eq("or_result", res0, 32'hF0F00F0F);
    idle(0, 2, 32'hF0F00F0F);

    run_op(0, 2'b11, 32'h0, 32'h0, -1);
    check_eq("nor_result", res0, 32'hFFFFFFFF);
    check_eq("nor_zero", {31'h0, zero0}, 32'h0);
    idle(0, 1, 32'hFFFFFFFF);

    run_op(0, 2'b10, 32'h12345678, 32'h12345678, -1);
    check_eq("xor_result", res0, 32'h0);
    check_eq("xor_zero", {31'h0, zero0}, {31'h0, ZERO_EN});
    idle(0, 1, 32'h0);

    // Asynchronous reset in the middle of a cycle must clear outputs at once.
    run_op(0, 2'b01, 32'hA5A5A5A5, 32'h0, -1);
    #3 reset = 1'b1;
    #1;
    check_eq("async_res", res0, 32'h0);
    check_eq("async_rdy", {31'h0, rdy0}, 32'h0);
    check_eq("async_busy", {31'h0, busy0}, 32'h0);
    #2 reset = 1'b0;
    idle(0, 2, 32'h0);

    run_op(0, 2'b01, 32'h00C300C3, 32'h11001100, 1);
    run_op(0, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, -1);
    check_eq("b2b_result", res0, 32'h0F0F0000);
    check_eq("b2b_gap", rdy_cyc - rdy_prev, 32'd5);
    idle(0, 1, 32'h0F0F0000);

    // Reset during RUN cycle 2 abandons the operation.
    op = 2'b01; a = 32'hFFFFFFFF; b = 32'h0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_res", res0, 32'h0);
    check_eq("midrst_busy", {31'h0, busy0}, 32'h0);
    #2 reset = 1'b0;
    idle(0, 8, 32'h0);
    run_op(0, 2'b10, 32'hDEADBEEF, 32'h0000FFFF, -1);
    check_eq("post_rst_result", res0, 32'hDEAD4110);
    idle(0, 1, 32'hDEAD4110);

    run_op(1, 2'b01, 32'h00FF, 32'hFF00, -1);
    check_eq("w16_result", {16'h0, res1}, 32'hFFFF);
    check_eq("w16_latency", rdy_cyc - start_cyc, 32'd1);
    idle(1, 1, 32'hFFFF);

    run_op(2, 2'b10, 32'hABC, 32'h5A5, -1);
    check_eq("w12_result", {20'h0, res2}, 32'hF19);
    check_eq("w12_latency", rdy_cyc - start_cyc, 32'd3);
    idle(2, 1, 32'hF19);

    for (int t = 0; t < 40; t++) begin
      int sel, pk;
      sel = int'($urandom_range(0, 2));
      pk  = ($urandom_range(0, 3) == 0) ?
            int'($urandom_range(0, cfg_width(sel) / cfg_slice(sel) - 1)) : -1;
      run_op(sel, 2'($urandom_range(0, 3)), $urandom, $urandom, pk);
      if ($urandom_range(0, 1) == 1) idle(sel, int'($urandom_range(1, 3)), last_exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
